// File: rtl/mu0_seq_alu_if.sv
// mu0_seq_alu_if: request/response bundle between the MU0 datapath and the sequential ALU
interface mu0_seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [2:0]       m;
    logic [WIDTH-1:0] q;
    logic             n;
    logic             z;
    logic             c;
    logic             busy;
    logic             done;
    modport master (output start, x, y, m, input q, n, z, c, busy, done);
    modport slave  (input start, x, y, m, output q, n, z, c, busy, done);
endinterface

// File: rtl/mu0_seq_alu.sv
// mu0_seq_alu: registered MU0 ALU with iterative multiply and shifts behind a start/busy/done handshake
module mu0_seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mu0_seq_alu_if.slave  alu
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, ITER} state_t;
    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_acc, r_mc, w_acc_nx;
    logic [WIDTH-1:0]   r_mp, r_sh, w_sh_nx;
    logic [WIDTH-1:0]   r_q, w_q1, w_q_nx;
    logic               r_n, r_z, r_c, r_done;
    logic               w_c1, w_c_nx, w_sh_out;
    logic [SHW-1:0]     w_s;
    logic               w_accept, w_long, w_last, w_load;
    logic [WIDTH:0]     w_add, w_inc, w_sub;

    // Decode the request, compute single-cycle results and the next iteration step
    always_comb begin
        w_s      = alu.y[SHW-1:0];
        w_accept = (r_state == IDLE) && alu.start;
        w_long   = (alu.m == 3'b101) || ((alu.m[2:1] == 2'b11) && (w_s != '0));
        w_last   = (r_state == ITER) && (r_cnt == CW'(1));
        w_add    = {1'b0, alu.x} + {1'b0, alu.y};
        w_inc    = {1'b0, alu.x} + (WIDTH+1)'(1);
        w_sub    = {1'b0, alu.x} + {1'b0, ~alu.y} + (WIDTH+1)'(1);
        w_q1     = (alu.m == 3'b000) ? alu.y :
                   (alu.m == 3'b001) ? w_add[WIDTH-1:0] :
                   (alu.m == 3'b010) ? w_inc[WIDTH-1:0] :
                   (alu.m == 3'b011) ? w_sub[WIDTH-1:0] :
                   (alu.m == 3'b100) ? (alu.x & alu.y) : alu.x;
        w_c1     = (alu.m == 3'b001) ? w_add[WIDTH] :
                   (alu.m == 3'b010) ? w_inc[WIDTH] :
                   (alu.m == 3'b011) ? w_sub[WIDTH] : 1'b0;
        w_acc_nx = r_mp[0] ? r_acc + r_mc : r_acc;
        w_sh_nx  = r_op[0] ? (r_sh >> 1) : (r_sh << 1);
        w_sh_out = r_op[0] ? r_sh[0] : r_sh[WIDTH-1];
        w_load   = (w_accept && !w_long) || w_last;
        w_q_nx   = !w_last ? w_q1 : (r_op == 3'b101) ? w_acc_nx[WIDTH-1:0] : w_sh_nx;
        w_c_nx   = !w_last ? w_c1 : (r_op == 3'b101) ? |w_acc_nx[2*WIDTH-1:WIDTH] : w_sh_out;
        w_next   = (w_accept && w_long) ? ITER : w_last ? IDLE : r_state;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Operand capture, iteration datapath and result/flag registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_acc  <= '0;
            r_mc   <= '0;
            r_mp   <= '0;
            r_sh   <= '0;
            r_q    <= '0;
            r_n    <= 1'b0;
            r_z    <= 1'b0;
            r_c    <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_q <= w_q_nx;
                r_n <= w_q_nx[WIDTH-1];
                r_z <= (w_q_nx == '0);
                r_c <= w_c_nx;
            end
            if (w_accept && w_long) begin
                r_op  <= alu.m;
                r_cnt <= (alu.m == 3'b101) ? CW'(WIDTH) : CW'(w_s);
                r_acc <= '0;
                r_mc  <= {{WIDTH{1'b0}}, alu.x};
                r_mp  <= alu.y;
                r_sh  <= alu.x;
            end else if (r_state == ITER) begin
                r_cnt <= r_cnt - CW'(1);
                r_acc <= w_acc_nx;
                r_mc  <= r_mc << 1;
                r_mp  <= r_mp >> 1;
                r_sh  <= w_sh_nx;
            end
        end
    end

    assign alu.q    = r_q;
    assign alu.n    = r_n;
    assign alu.z    = r_z;
    assign alu.c    = r_c;
    assign alu.busy = (r_state == ITER);
    assign alu.done = r_done;
endmodule

// File: tb/tb_mu0_seq_alu.sv
// tb_mu0_seq_alu: directed vectors with a done-driven scoreboard monitor
module tb_mu0_seq_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    typedef struct {
        logic [15:0] q;
        logic        c;
    } exp_t;
    exp_t sb[$];

    mu0_seq_alu_if #(.WIDTH(16)) alu();
    mu0_seq_alu #(.WIDTH(16)) dut (.i_clk(clk), .i_rst(rst), .alu(alu));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every Done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (alu.done) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL spurious_done: got q=%h with no request outstanding", alu.q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (alu.q !== e.q || alu.c !== e.c || alu.n !== e.q[15] || alu.z !== (e.q == 16'h0)) begin
                    bad++;
                    $display("FAIL result: got q=%h n=%b z=%b c=%b, want q=%h n=%b z=%b c=%b",
                             alu.q, alu.n, alu.z, alu.c, e.q, e.q[15], (e.q == 16'h0), e.c);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] m, input logic [15:0] x, input logic [15:0] y);
        alu.start = 1'b1;
        alu.m = m;
        alu.x = x;
        alu.y = y;
        @(posedge clk);
        @(negedge clk);
        alu.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lat0, input int exp_lat);
        int lat = lat0;
        int bb = 0;
        while (!alu.done && lat < 60) begin
            if (alu.busy !== 1'b1) bb++;
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != exp_lat || bb != 0 || alu.busy !== 1'b0 || alu.done !== 1'b1) begin
            bad++;
            $display("FAIL %s timing: got latency=%0d busy_gaps=%0d busy_at_done=%b, want latency=%0d",
                     nm, lat, bb, alu.busy, exp_lat);
        end
    endtask

    task automatic op(input string nm, input logic [2:0] m, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] eq, input logic ec, input int lat);
        exp_t e;
        e.q = eq;
        e.c = ec;
        sb.push_back(e);
        drive(m, x, y);
        wait_done(nm, 1, lat);
    endtask

    task automatic check_reset_state(input string nm);
        total++;
        if ({alu.q, alu.n, alu.z, alu.c, alu.busy, alu.done} !== 21'h0) begin
            bad++;
            $display("FAIL %s: got q=%h n=%b z=%b c=%b busy=%b done=%b, want all zero",
                     nm, alu.q, alu.n, alu.z, alu.c, alu.busy, alu.done);
        end
    endtask

    initial begin
        exp_t e;
        alu.start = 1'b0;
        alu.m = 3'b000;
        alu.x = 16'h0;
        alu.y = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_values");
        rst = 1'b0;
        @(negedge clk);
        op("add_wrap",   3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1);
        op("sub_borrow", 3'b011, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1);
        op("sub_ok",     3'b011, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1);
        op("mul",        3'b101, 16'h0123, 16'h0010, 16'h1230, 1'b0, 17);
        op("mul_ovf",    3'b101, 16'h1000, 16'h0010, 16'h0000, 1'b1, 17);
        op("shl1",       3'b110, 16'h8001, 16'h0001, 16'h0002, 1'b1, 2);
        op("shr0",       3'b111, 16'h8001, 16'h0000, 16'h8001, 1'b0, 1);
        op("pass_y",     3'b000, 16'hAAAA, 16'h1234, 16'h1234, 1'b0, 1);
        op("and",        3'b100, 16'hF0F0, 16'h3CCC, 16'h30C0, 1'b0, 1);
        op("inc_wrap",   3'b010, 16'hFFFF, 16'h5555, 16'h0000, 1'b1, 1);
        op("shr4",       3'b111, 16'h8001, 16'h0004, 16'h0800, 1'b0, 5);
        op("shl4",       3'b110, 16'hF000, 16'h0004, 16'h0000, 1'b1, 5);
        op("shr5",       3'b111, 16'h00F0, 16'h0005, 16'h0007, 1'b1, 6);
        op("shl_ylow",   3'b110, 16'h0001, 16'h0014, 16'h0010, 1'b0, 5);
        op("mul_max",    3'b101, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 17);
        e.q = 16'h1230;
        e.c = 1'b0;
        sb.push_back(e);
        drive(3'b101, 16'h0123, 16'h0010);
        repeat (3) @(negedge clk);
        alu.start = 1'b1;
        alu.m = 3'b001;
        alu.x = 16'hFFFF;
        alu.y = 16'hFFFF;
        @(negedge clk);
        alu.start = 1'b0;
        alu.x = 16'h0;
        alu.y = 16'h0;
        wait_done("mul_ignore_start", 5, 17);
        op("back_to_back", 3'b001, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1);
        repeat (3) @(negedge clk);
        drive(3'b101, 16'h0123, 16'h0010);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset_mid_mul");
        repeat (25) @(negedge clk);
        check_reset_state("no_done_after_abort");
        op("inc_after_reset", 3'b010, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1);
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d outstanding, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mu0_seq_alu.md
Name: mu0_seq_alu

Overview:
Parametrised, registered successor to the MU0 combinational ALU. It keeps the four MU0 operations (pass Y, add, increment X, subtract) and adds AND, iterative shift-add multiply, and iterative logical shifts. Results and N/Z/C flags are registered, and a Start/Busy/Done handshake supports multi-cycle operations. It sits between the MU0 datapath registers and the accumulator write-back.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
SHW, $clog2(WIDTH), number of Y low bits used as shift amount

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request: capture X, Y, M this edge (only honoured when Busy=0)
X  input  WIDTH  operand A
Y  input  WIDTH  operand B / shift amount
M  input  3  operation select
Q  output  WIDTH  registered result
N  output  1  negative flag, Q[WIDTH-1]
Z  output  1  zero flag, Q==0
C  output  1  carry/borrow/overflow flag
Busy  output  1  high while a multi-cycle operation iterates
Done  output  1  one-cycle pulse: Q/N/Z/C just updated

Behaviour:
- One clock, Clk. Reset is synchronous and active-high; it dominates all other inputs.
- Reset values: Q=0, N=0, Z=0, C=0, Busy=0, Done=0, state=IDLE, iteration counter=0.
- Op codes (M):
  - 000 Q=Y, C=0.
  - 001 Q=X+Y, C=carry out.
  - 010 Q=X+1, C=carry out.
  - 011 Q=X-Y (X+~Y+1), C=1 when no borrow (X>=Y unsigned).
  - 100 Q=X&Y, C=0.
  - 101 MUL: Q=low WIDTH bits of X*Y (unsigned); C=1 if the high WIDTH bits are non-zero.
  - 110 SHL: Q=X<<S, S=Y[SHW-1:0]; C=last bit shifted out, C=0 when S=0.
  - 111 SHR (logical): Q=X>>S, C=last bit shifted out, C=0 when S=0.
- All arithmetic is modulo 2^WIDTH. The multiply product register is 2*WIDTH bits internally.
- States:
  - IDLE: Busy=0. Start=1 latches X, Y, M.
    - Single-cycle ops (000-100), and SHL/SHR with S=0: Q and flags load on the same edge; Done=1 the following cycle; stay IDLE. Latency 1.
    - MUL: go to ITER, counter=WIDTH.
    - SHL/SHR with S>0: go to ITER, counter=S.
  - ITER: Busy=1.
    - MUL: one shift-add step per edge (LSB of multiplier).
    - SHL/SHR: one 1-bit shift per edge.
    - counter decrements each edge. When it reaches 0, load Q and flags, pulse Done, return to IDLE.
    - MUL latency WIDTH+1 cycles from the Start edge to Done; shift latency S+1.
- Q, N, Z, C change only on Done edges (and reset). They hold between operations. Intermediate iteration values never appear on Q.
- N and Z are always derived from the new Q value.
- Operands are latched at Start; X/Y/M changes while Busy=1 have no effect.
- Start while Busy=1 is ignored; it is not queued.
- Start in the cycle Done=1 (state IDLE) is accepted: back-to-back operations are allowed.
- Start=0 in IDLE: no state or output change; Done=0.
- Reset mid-ITER: the operation is aborted. Next cycle all outputs are at reset values, and no Done pulse is produced for the aborted operation.
- Done is never high for two consecutive cycles unless two single-cycle Starts occur back-to-back.

Test Plan:
- Reset, then M=001, X=0xFFFF, Y=0x0001, Start one cycle -> next cycle Done=1, Q=0x0000, Z=1, C=1, N=0, Busy=0 throughout.
- M=011, X=0x0003, Y=0x0005 -> Q=0xFFFE, N=1, Z=0, C=0. Repeat with X=0x0005, Y=0x0003 -> Q=0x0002, C=1.
- M=101, X=0x0123, Y=0x0010 -> Busy=1 for 16 cycles, Done on cycle 17, Q=0x1230, C=0. Then X=0x1000, Y=0x0010 -> Q=0x0000, Z=1, C=1.
- M=110, X=0x8001, Y=0x0001 -> Done on cycle 2, Q=0x0002, C=1. M=111, X=0x8001, Y=0x0000 -> Done on cycle 1, Q=0x8001, N=1, C=0.
- During a MUL, pulse Start with M=001 and change X/Y -> second request ignored, MUL result unaffected, exactly one Done. Back-to-back Start on the Done cycle -> second op completes correctly.
- Assert Reset at cycle 5 of a MUL -> next cycle Q=0, N=Z=C=0, Busy=0, no Done. Subsequent M=010, X=0x00FF -> Q=0x0100.
